// File: rtl/platform_pkg.sv
// platform_pkg: shared FSM states, half-step coil table, colour bit positions and default bin settings
package platform_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  localparam logic [31:0] COIL_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000};
  localparam int RED = 0;
  localparam int BROWN = 1;
  localparam int YELLOW = 2;
  localparam int ORANGE = 3;
  localparam int BLUE = 4;
  localparam int GREEN = 5;
  localparam int NUM_BINS_DEF = 6;
  localparam int STEPS_W_DEF = 12;
  localparam logic [NUM_BINS_DEF*STEPS_W_DEF-1:0] BIN_STEPS_DEF = {12'd25, 12'd50, 12'd75, 12'd100, 12'd75, 12'd50};
  localparam logic [NUM_BINS_DEF-1:0] BIN_DIR_DEF = 6'b111000;
  function automatic logic [3:0] coil_of(input logic [2:0] phase);
    return COIL_TBL[{phase, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/stepper_phase_gen.sv
// stepper_phase_gen: phase index + step divider; en high advances on each divider expiry (step_tick) and clears the divider when low; coil = table[phase]
module stepper_phase_gen import platform_pkg::*; #(
  parameter int STEP_DIV = 97_656,
  parameter bit HALF_STEP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  output logic       step_tick,
  output logic [3:0] coil
);
  localparam int DW = $clog2(STEP_DIV);
  localparam logic [2:0] INC = HALF_STEP ? 3'd1 : 3'd2;
  logic [DW-1:0] div;
  logic [2:0] phase;
  assign step_tick = div == '0;
  assign coil = coil_of(phase);
  always_ff @(posedge clk)
    if (rst) begin
      div <= '0;
      phase <= '0;
    end else if (!en) begin
      div <= '0;
    end else if (step_tick) begin
      phase <= dir ? phase - INC : phase + INC;
      div <= DW'(STEP_DIV - 1);
    end else begin
      div <= div - 1'b1;
    end
endmodule

// File: rtl/platform_return_ctrl.sv
// platform_return_ctrl: colour-selected stepper return move (clk, rst, start, colour, abort in; coil, busy, done, err out)
module platform_return_ctrl import platform_pkg::*; #(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int STEPS_W = STEPS_W_DEF,
  parameter logic [NUM_BINS*STEPS_W-1:0] BIN_STEPS = BIN_STEPS_DEF,
  parameter logic [NUM_BINS-1:0] BIN_DIR = BIN_DIR_DEF,
  parameter int STEP_DIV = 97_656,
  parameter int HOLD_CYC = 1_000_000,
  parameter bit HALF_STEP = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BINS-1:0] colour,
  input  logic                abort,
  output logic [3:0]          coil,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int BW = NUM_BINS > 1 ? $clog2(NUM_BINS) : 1;
  state_t state;
  logic [STEPS_W-1:0] rem;
  logic [HW-1:0] hold;
  logic [BW-1:0] idx;
  logic [STEPS_W-1:0] sel_steps;
  logic [3:0] gen_coil;
  logic dir_q, tick, en, accept;
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_BINS; i++) idx = colour[i] ? BW'(i) : idx;
  end
  assign sel_steps = BIN_STEPS[idx*STEPS_W +: STEPS_W];
  assign accept = state == IDLE && start && $onehot(colour);
  assign en = (accept && sel_steps != '0) || (state == RUN && !abort && !(tick && rem == STEPS_W'(1)));
  assign coil = busy ? gen_coil : 4'b0000;
  stepper_phase_gen #(.STEP_DIV(STEP_DIV), .HALF_STEP(HALF_STEP)) u_gen (
    .clk(clk),
    .rst(rst),
    .en(en),
    .dir(state == IDLE ? BIN_DIR[idx] : dir_q),
    .step_tick(tick),
    .coil(gen_coil)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      hold <= '0;
      dir_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            rem <= sel_steps;
            dir_q <= BIN_DIR[idx];
            state <= sel_steps == '0 ? DONE : RUN;
            done <= sel_steps == '0;
            busy <= sel_steps != '0;
          end else if (start) begin
            err <= 1'b1;
          end
        RUN:
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (tick) begin
            rem <= rem - 1'b1;
            state <= rem == STEPS_W'(1) ? HOLD : RUN;
            hold <= HW'(HOLD_CYC - 1);
          end
        HOLD:
          if (abort || hold == '0) begin
            state <= abort ? IDLE : DONE;
            busy <= 1'b0;
            done <= !abort;
          end else begin
            hold <= hold - 1'b1;
          end
        DONE: state <= IDLE;
      endcase
    end
endmodule
